serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/full_adder_cell.sv | 24 ++
 rtl/serial_adder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : Shared types and constants for the bit-serial adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int WIDTH_DEFAULT = 8;

  // Controller states: waiting, shifting bits through the cell, result ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder_cell.sv
//------------------------------------------------------------------------------
// Module   : full_adder_cell
// Brief    : Combinational 1-bit full adder used as the serial arithmetic core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  // Sum and majority-carry of the three input bits.
  always_comb begin
    s_o    = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule : full_adder_cell

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Brief    : Bit-serial adder/subtractor, LSB first, one bit per clock through
//            a single full-adder cell and a 1-bit carry register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             n_reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_s;
  logic               fa_c;
  logic               start_ok;
  logic               last_bit;

  // START is only honoured when no operation is in flight.
  assign start_ok = start_i && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  full_adder_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_c)
  );

  // State register; reset wins over any START sampled on the same edge.
  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the IDLE -> RUN -> FIN sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == FIN);
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle.
  // The A register doubles as the partial-sum accumulator: each sum bit
  // enters at the MSB, so after WIDTH shifts it holds the full result.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (start_ok) begin
      cnt_d   = '0;
      a_d     = a_i;
      b_d     = sub_i ? ~b_i : b_i;
      carry_d = sub_i ? 1'b1 : cin_i;
    end else if (state_q == RUN) begin
      cnt_d   = cnt_q + CNT_W'(1);
      a_d     = {fa_s, a_q[WIDTH-1:1]};
      b_d     = {1'b0, b_q[WIDTH-1:1]};
      carry_d = fa_c;
      if (last_bit) begin
        cnt_d  = '0;
        sum_d  = {fa_s, a_q[WIDTH-1:1]};
        cout_d = fa_c;
        // carry_q here is the carry into the MSB.
        ovf_d  = carry_q ^ fa_c;
      end
    end
  end

  // Datapath registers and held result outputs.
  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule : serial_adder

`default_nettype wire
